fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock FIFO; the read-domain counterpart of the write port into fifo_mem.
- Synchronises the write-domain Gray pointer into rclk.
- Maintains the read pointer and the empty flag.
- Drives the memory read address.
- Presents data through a one-entry show-ahead output register with a valid/ready handshake.

Parameters:
DATA_SIZE  8  word width, must match the memory.
ADD_SIZE   4  memory address width; DEPTH = 1<<ADD_SIZE; pointers are ADD_SIZE+1 bits.

Ports:
rclk       input   1            read clock; all state updates on its rising edge.
rrst       input   1            asynchronous, active-high reset.
wptr       input   ADD_SIZE+1   write pointer, Gray-coded, from the write domain. At most one bit changes per write-clock edge.
mem_rdata  input   DATA_SIZE    memory read data; combinational from raddr.
raddr      output  ADD_SIZE     memory read address = rbin[ADD_SIZE-1:0].
rptr       output  ADD_SIZE+1   registered Gray read pointer, sent to the write domain.
rempty     output  1            registered; memory holds no unread word.
rdata      output  DATA_SIZE    output-register data.
rvalid     output  1            rdata is valid.
rready     input   1            consumer accepts rdata when rvalid && rready.
rlevel     output  ADD_SIZE+1   words in memory not yet fetched; excludes the output register.

Behaviour:
- Reset (async, while rrst=1), applies immediately, including mid-operation; any held word is discarded:
  - rq1_wptr = rq2_wptr = 0.
  - rbin = 0, rptr = 0, raddr = 0.
  - rempty = 1, rvalid = 0, rdata = 0, rlevel = 0.
- Synchroniser: two flops, wptr -> rq1_wptr -> rq2_wptr. No other logic touches the unsynchronised wptr.
- Fetch condition: fetch = !rempty && (!rvalid || rready).
- Pointers:
  - rbinnext = rbin + fetch, modulo 2^(ADD_SIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Each edge: rbin <= rbinnext, rptr <= rgraynext.
- Empty flag: rempty <= (rgraynext == rq2_wptr).
- Output register, on each edge:
  - If fetch: rdata <= mem_rdata (word at the current raddr), rvalid <= 1.
  - Else if rvalid && rready: rvalid <= 0; rdata holds its last value.
  - Else: rdata and rvalid hold.
- Handshake:
  - rdata and rvalid must not change while rvalid=1 && rready=0.
  - Back-to-back throughput is one word per rclk while data is available and rready=1.
- Latency: with wptr stable before edge E1, rq2_wptr updates at E2 and rempty falls at E3. fetch is high in the cycle after E3, so rvalid=1 with the first word at E4.
- rlevel (combinational): gray2bin(rq2_wptr) - rbin, ADD_SIZE+1 bits, modulo arithmetic; range 0..DEPTH.
- Wrap-around:
  - raddr wraps from DEPTH-1 to 0.
  - The MSB of rbin toggles each lap; empty compare uses the full ADD_SIZE+1 bits.
- Boundary cases:
  - Last word fetched: rempty rises at the same edge as the fetch.
  - Fetch and consume in the same cycle: rvalid stays 1 and rdata is replaced.
  - rready with rvalid=0: no effect.
  - rempty=1: rbin, raddr and rptr must not move.
  - The write side may advance wptr while rempty=1; rempty stays 1 until the new value reaches rq2_wptr.

Test Plan:
1. Reset, ADD_SIZE=4: rrst pulse mid-cycle -> outputs cleared asynchronously: rempty=1, rvalid=0, rptr=0, raddr=0, rlevel=0.
2. First-word latency: wptr 0->1 (Gray 00001) before E1, mem_rdata=8'hA5 at addr 0, rready=1 -> rempty=0 after E3; rvalid=1 and rdata=A5 after E4; rptr=00001; rempty=1 again at that same edge.
3. Backpressure: 3 words (11,22,33) available, rready=0 -> rvalid=1, rdata=11 held indefinitely, rlevel=2. Then rready=1 for 3 cycles -> 22, 33 on consecutive edges; rvalid drops the cycle after 33 is accepted.
4. Full drain / wrap:
   - Set wptr for a full memory (bin 16, Gray 11000) with rptr=0 -> rlevel=16.
   - Stream with rready=1 -> 16 consecutive words, raddr 0..15.
   - End state: rptr=11000, rempty=1.
   - A second lap advances wptr to bin 0 (Gray 00000) -> raddr restarts at 0, rbin MSB returns to 0.
5. Reset mid-stream: rrst during a burst with rvalid=1 -> rvalid=0 and rptr=0 immediately; after release, rempty=1 until wptr is re-synchronised.
6. Random wptr increments with random rready, compared against a reference model -> data order and count match exactly; rvalid never deasserts without a handshake; rlevel never exceeds 16.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: synchronises the write pointer, tracks the
// read pointer and empty flag, and serves data through a one-entry show-ahead output register.
module fifo_rd_ctrl #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADD_SIZE  = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [ADD_SIZE:0]    wptr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [ADD_SIZE-1:0]  raddr,
    output logic [ADD_SIZE:0]    rptr,
    output logic                 rempty,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [ADD_SIZE:0]    rlevel
);

    localparam int unsigned PtrW = ADD_SIZE + 1;

    function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
        logic [PtrW-1:0] b;
        for (int i = 0; i < PtrW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PtrW-1:0] rq1_wptr;
    logic [PtrW-1:0] rq2_wptr;
    logic [PtrW-1:0] rq2_wbin;
    logic [PtrW-1:0] rbin;
    logic [PtrW-1:0] rbinnext;
    logic [PtrW-1:0] rgraynext;
    logic            fetch;
    logic            consume;

    // Only the first synchroniser flop ever samples the write-domain pointer.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

    always_comb begin
        fetch     = !rempty && (!rvalid || rready);
        consume   = rvalid && rready;
        rbinnext  = rbin + {{ADD_SIZE{1'b0}}, fetch};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        rq2_wbin  = gray2bin(rq2_wptr);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            // Full-width compare so a lapped pointer is not mistaken for empty.
            rempty <= (rgraynext == rq2_wptr);
        end
    end

    // Show-ahead register: refill whenever it is empty or being drained this cycle.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (fetch) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (consume) begin
            rvalid <= 1'b0;
        end
    end

    assign raddr  = rbin[ADD_SIZE-1:0];
    assign rlevel = rq2_wbin - rbin;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: table-driven latency/backpressure vectors, then
// directed wrap and reset sequences and a randomised stream checked by a scoreboard.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [4:0] wptr;
    logic [7:0] mem_rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic [4:0] rlevel;

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(
        .DATA_SIZE(8),
        .ADD_SIZE (4)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr     (wptr),
        .mem_rdata(mem_rdata),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .rlevel   (rlevel)
    );

    logic [7:0] mem [16];
    assign mem_rdata = mem[raddr];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        b[3] = b[4] ^ g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    // Write-side model and scoreboard
    logic [7:0] exp_q[$];
    bit         sb_en = 1'b0;
    logic [4:0] wbin;
    int         n_wr = 0;
    int         n_rd = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    function automatic bit has_space();
        logic [4:0] occ;
        occ = wbin - g2b(rptr);
        return occ < 5'd16;
    endfunction

    task automatic wr_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 5'd1;
        wptr = wbin ^ (wbin >> 1);
        n_wr++;
    endtask

    always @(negedge rclk) begin
        if (sb_en && !rrst) begin
            if (prev_hold) begin
                check("hold.rvalid", {31'b0, rvalid}, 32'd1);
                check("hold.rdata", {24'b0, rdata}, {24'b0, prev_data});
            end
            check("rlevel.max", {31'b0, rlevel <= 5'd16}, 32'd1);
            if (rvalid && rready) begin
                check("sb.expected_word", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb.data", {24'b0, rdata}, {24'b0, exp_q.pop_front()});
                    n_rd++;
                end
            end
            prev_hold <= rvalid && !rready;
            prev_data <= rdata;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    typedef struct {
        logic [4:0] wptr;
        logic       rready;
        logic       rempty;
        logic       rvalid;
        logic [7:0] rdata;
        logic [4:0] rptr;
        logic [4:0] rlevel;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // First-word latency, then three words under backpressure
        vecs[0]  = '{5'h01, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00, 5'd0};
        vecs[1]  = '{5'h01, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00, 5'd1};
        vecs[2]  = '{5'h01, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00, 5'd1};
        vecs[3]  = '{5'h01, 1'b1, 1'b1, 1'b1, 8'hA5, 5'h01, 5'd0};
        vecs[4]  = '{5'h01, 1'b1, 1'b1, 1'b0, 8'hA5, 5'h01, 5'd0};
        vecs[5]  = '{5'h03, 1'b0, 1'b1, 1'b0, 8'hA5, 5'h01, 5'd0};
        vecs[6]  = '{5'h02, 1'b0, 1'b1, 1'b0, 8'hA5, 5'h01, 5'd1};
        vecs[7]  = '{5'h06, 1'b0, 1'b0, 1'b0, 8'hA5, 5'h01, 5'd2};
        vecs[8]  = '{5'h06, 1'b0, 1'b0, 1'b1, 8'h11, 5'h03, 5'd2};
        vecs[9]  = '{5'h06, 1'b0, 1'b0, 1'b1, 8'h11, 5'h03, 5'd2};
        vecs[10] = '{5'h06, 1'b0, 1'b0, 1'b1, 8'h11, 5'h03, 5'd2};
        vecs[11] = '{5'h06, 1'b1, 1'b0, 1'b1, 8'h22, 5'h02, 5'd1};
        vecs[12] = '{5'h06, 1'b1, 1'b1, 1'b1, 8'h33, 5'h06, 5'd0};
        vecs[13] = '{5'h06, 1'b1, 1'b1, 1'b0, 8'h33, 5'h06, 5'd0};
        vecs[14] = '{5'h06, 1'b0, 1'b1, 1'b0, 8'h33, 5'h06, 5'd0};

        rrst   = 1'b1;
        wptr   = '0;
        rready = 1'b0;
        wbin   = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        mem[1] = 8'h11;
        mem[2] = 8'h22;
        mem[3] = 8'h33;
        #2;
        check("por.rempty", {31'b0, rempty}, 32'd1);
        check("por.rvalid", {31'b0, rvalid}, 32'd0);
        check("por.rptr", {27'b0, rptr}, 32'd0);
        check("por.rlevel", {27'b0, rlevel}, 32'd0);
        #10 rrst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            wptr   = vecs[i].wptr;
            rready = vecs[i].rready;
            step();
            check($sformatf("vec%0d.rempty", i), {31'b0, rempty}, {31'b0, vecs[i].rempty});
            check($sformatf("vec%0d.rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].rvalid});
            check($sformatf("vec%0d.rdata", i), {24'b0, rdata}, {24'b0, vecs[i].rdata});
            check($sformatf("vec%0d.rptr", i), {27'b0, rptr}, {27'b0, vecs[i].rptr});
            check($sformatf("vec%0d.rlevel", i), {27'b0, rlevel}, {27'b0, vecs[i].rlevel});
        end

        // Asynchronous reset mid-cycle
        #2;
        rrst = 1'b1;
        wptr = '0;
        #1;
        check("arst.rempty", {31'b0, rempty}, 32'd1);
        check("arst.rvalid", {31'b0, rvalid}, 32'd0);
        check("arst.rdata", {24'b0, rdata}, 32'd0);
        check("arst.rptr", {27'b0, rptr}, 32'd0);
        check("arst.raddr", {28'b0, raddr}, 32'd0);
        check("arst.rlevel", {27'b0, rlevel}, 32'd0);
        #2 rrst = 1'b0;

        // Full memory, first lap
        for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
        step();
        wptr = 5'b11000;
        step();
        step();
        check("full.rlevel", {27'b0, rlevel}, 32'd16);
        check("full.rempty", {31'b0, rempty}, 32'd1);
        rready = 1'b1;
        step();
        check("full.rempty_fall", {31'b0, rempty}, 32'd0);
        check("full.rvalid_pre", {31'b0, rvalid}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("lap1.raddr%0d", k), {28'b0, raddr}, k);
            step();
            check($sformatf("lap1.rvalid%0d", k), {31'b0, rvalid}, 32'd1);
            check($sformatf("lap1.rdata%0d", k), {24'b0, rdata}, 32'h40 + k);
        end
        check("lap1.rempty", {31'b0, rempty}, 32'd1);
        check("lap1.rptr", {27'b0, rptr}, 32'h18);
        check("lap1.raddr", {28'b0, raddr}, 32'd0);
        check("lap1.rlevel", {27'b0, rlevel}, 32'd0);
        step();
        check("lap1.rvalid_drop", {31'b0, rvalid}, 32'd0);

        // Second lap back to pointer zero
        wbin  = 5'd16;
        n_wr  = 0;
        n_rd  = 0;
        sb_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (has_space()) wr_word(8'h80 + 8'(i));
            step();
        end
        for (int i = 0; i < 100 && (exp_q.size() > 0 || rvalid); i++) step();
        check("lap2.drained", exp_q.size(), 32'd0);
        check("lap2.count", n_rd, 32'd16);
        check("lap2.rptr", {27'b0, rptr}, 32'd0);
        check("lap2.raddr", {28'b0, raddr}, 32'd0);
        check("lap2.rempty", {31'b0, rempty}, 32'd1);

        // Reset in the middle of a burst
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_word(8'hC0 + 8'(i));
            step();
        end
        for (int i = 0; i < 10 && !rvalid; i++) step();
        check("mrst.rvalid_before", {31'b0, rvalid}, 32'd1);
        #2;
        rrst  = 1'b1;
        sb_en = 1'b0;
        #1;
        check("mrst.rvalid", {31'b0, rvalid}, 32'd0);
        check("mrst.rptr", {27'b0, rptr}, 32'd0);
        check("mrst.raddr", {28'b0, raddr}, 32'd0);
        check("mrst.rempty", {31'b0, rempty}, 32'd1);
        exp_q.delete();
        #2 rrst = 1'b0;
        step();
        check("mrst.sync1_rempty", {31'b0, rempty}, 32'd1);
        step();
        check("mrst.sync2_rempty", {31'b0, rempty}, 32'd1);
        check("mrst.sync2_rlevel", {27'b0, rlevel}, 32'd3);
        step();
        check("mrst.sync3_rempty", {31'b0, rempty}, 32'd0);

        // Random stream against the scoreboard
        rrst = 1'b1;
        wptr = '0;
        wbin = '0;
        n_wr = 0;
        n_rd = 0;
        step();
        rrst  = 1'b0;
        sb_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rready = ($urandom_range(0, 3) != 0);
            if (has_space() && $urandom_range(0, 2) != 0) wr_word(8'($urandom));
            step();
        end
        rready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() > 0 || rvalid); i++) step();
        check("rand.drained", exp_q.size(), 32'd0);
        check("rand.count", n_rd, n_wr);
        check("rand.rempty", {31'b0, rempty}, 32'd1);
        check("rand.rlevel", {27'b0, rlevel}, 32'd0);
        sb_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
